// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS-style integer ALU: op-code constants and
// status-word bit positions used by the ALU datapath and its testbench.
package alu_pkg;

   localparam int CONTROL_WIDTH = 5;
   localparam int STATUS_WIDTH  = 4;

   // Operation select codes; codes 11..31 are unused.
   localparam logic [CONTROL_WIDTH-1:0] AND  = 5'd0;
   localparam logic [CONTROL_WIDTH-1:0] OR   = 5'd1;
   localparam logic [CONTROL_WIDTH-1:0] NOR  = 5'd2;
   localparam logic [CONTROL_WIDTH-1:0] ADD  = 5'd3;
   localparam logic [CONTROL_WIDTH-1:0] SUB  = 5'd4;
   localparam logic [CONTROL_WIDTH-1:0] XOR  = 5'd5;
   localparam logic [CONTROL_WIDTH-1:0] SLT  = 5'd6;
   localparam logic [CONTROL_WIDTH-1:0] SLTU = 5'd7;
   localparam logic [CONTROL_WIDTH-1:0] SLL  = 5'd8;
   localparam logic [CONTROL_WIDTH-1:0] SRL  = 5'd9;
   localparam logic [CONTROL_WIDTH-1:0] SRA  = 5'd10;

   // Status word layout {V, N, Z, C}.
   localparam int STATUS_V_BIT = 3;
   localparam int STATUS_N_BIT = 2;
   localparam int STATUS_Z_BIT = 1;
   localparam int STATUS_C_BIT = 0;

endpackage

// File: rtl/alu_adder.sv
// DATA_WIDTH-bit adder with optional B inversion and carry-in. Shared by
// ADD, SUB, SLT and SLTU; reports carry-out and two's-complement overflow.
module alu_adder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  invert_b,
   input  logic                  carry_in,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  carry_out,
   output logic                  overflow
);

   logic [DATA_WIDTH-1:0] b_eff;

   assign b_eff = invert_b ? ~b : b;

   // One extra bit on each addend so the carry-out falls out of the sum.
   assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, carry_in};

   // Overflow: addends share a sign that the result does not.
   assign overflow = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                     (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Parameterised integer ALU with registered result and status (latency 1).
// Optional shifter (SLL/SRL/SRA) is built only when ALU_SHIFT_EN is defined;
// otherwise codes 8..10 behave as unused codes.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CONTROL_WIDTH-1:0] control,
   input  logic [DATA_WIDTH-1:0]    a,
   input  logic [DATA_WIDTH-1:0]    b,
   input  logic [STATUS_WIDTH-1:0]  si,
   output logic [DATA_WIDTH-1:0]    out,
   output logic [STATUS_WIDTH-1:0]  so
);

   logic                    invert_b;
   logic                    carry_in;
   logic [DATA_WIDTH-1:0]   sum;
   logic                    carry_out;
   logic                    overflow;
   logic [DATA_WIDTH-1:0]   result;
   logic [STATUS_WIDTH-1:0] status;

`ifdef ALU_SHIFT_EN
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
   logic [SHAMT_WIDTH-1:0] shamt;
   assign shamt = b[SHAMT_WIDTH-1:0];
`endif

   // Adder set-up: everything but ADD inverts B; compares force a+~b+1.
   always_comb begin
      invert_b = (control != ADD);
      carry_in = ((control == SLT) || (control == SLTU)) ? 1'b1 : si[STATUS_C_BIT];
   end

   alu_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
      .a         (a),
      .b         (b),
      .invert_b  (invert_b),
      .carry_in  (carry_in),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // Result mux and status generation.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      result               = '0;
      status               = '0;
      status[STATUS_C_BIT] = si[STATUS_C_BIT];
      status[STATUS_V_BIT] = si[STATUS_V_BIT];
      case (control)
         AND:  result = a & b;
         OR:   result = a | b;
         NOR:  result = ~(a | b);
         XOR:  result = a ^ b;
         ADD, SUB: begin
            result               = sum;
            status[STATUS_C_BIT] = carry_out;
            status[STATUS_V_BIT] = overflow;
         end
         // Signed less-than: sign of a-b corrected by overflow.
         SLT:  result = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ overflow};
         // Unsigned less-than: a borrow occurred (no carry-out).
         SLTU: result = {{(DATA_WIDTH-1){1'b0}}, ~carry_out};
`ifdef ALU_SHIFT_EN
         SLL:  result = a << shamt;
         SRL:  result = a >> shamt;
         SRA:  result = DATA_WIDTH'($signed(a) >>> shamt);
`endif
         default: result = '0;
      endcase
      status[STATUS_N_BIT] = result[DATA_WIDTH-1];
      status[STATUS_Z_BIT] = (result == '0);
   end

   // Output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         out <= '0;
         so  <= '0;
      end else begin
         out <= result;
         so  <= status;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with hand-computed results.
// The driver pushes each expected {out, so} into a queue; a monitor pops one
// entry one edge later and compares. Shift vectors depend on ALU_SHIFT_EN.
module tb_alu;
   import alu_pkg::*;

   localparam int W = 32;

   typedef struct {
      string         name;
      logic [W-1:0]  exp_out;
      logic [3:0]    exp_so;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [CONTROL_WIDTH-1:0] control = '0;
   logic [W-1:0]             a = '0;
   logic [W-1:0]             b = '0;
   logic [3:0]               si = '0;
   logic [W-1:0]             out;
   logic [3:0]               so;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu #(.DATA_WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .control (control),
      .a       (a),
      .b       (b),
      .si      (si),
      .out     (out),
      .so      (so)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one operation for the coming edge and record its expected response.
   task automatic issue(input string name, input logic rst, input logic [4:0] ctl,
                        input logic [W-1:0] va, input logic [W-1:0] vb, input logic [3:0] vsi,
                        input logic [W-1:0] eo, input logic [3:0] es);
      exp_t e;
      @(negedge clk);
      rst_n   = rst;
      control = ctl;
      a       = va;
      b       = vb;
      si      = vsi;
      e.name    = name;
      e.exp_out = eo;
      e.exp_so  = es;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are valid every cycle, one edge after issue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".out"}, 64'(out), 64'(e.exp_out));
            check({e.name, ".so"},  64'(so),  64'(e.exp_so));
         end
      end
   end

   initial begin
      //     name           rst  ctl   a             b             si       out           so{VNZC}
      issue("reset",        0,   ADD,  32'hDEADBEEF, 32'h12345678, 4'hF,    32'h0,        4'b0000);
      issue("and",          1,   AND,  32'hF000000F, 32'hF00000F0, 4'h0,    32'hF0000000, 4'b0100);
      issue("or",           1,   OR,   32'hF000000F, 32'hF00000F0, 4'h0,    32'hF00000FF, 4'b0100);
      issue("nor",          1,   NOR,  32'hF000000F, 32'hF00000F0, 4'h0,    32'h0FFFFF00, 4'b0000);
      issue("xor",          1,   XOR,  32'hF000000F, 32'hF00000F0, 4'h0,    32'h000000FF, 4'b0000);
      issue("and_pass_cv",  1,   AND,  32'hF000000F, 32'hF00000F0, 4'b1001, 32'hF0000000, 4'b1101);
      issue("add_ovf",      1,   ADD,  32'h7FFFFFFF, 32'h1,        4'h0,    32'h80000000, 4'b1100);
      issue("add_cin",      1,   ADD,  32'hABC,      32'h123,      4'b0001, 32'hBE0,      4'b0000);
      issue("sub",          1,   SUB,  32'hABC,      32'h123,      4'b0001, 32'h999,      4'b0001);
      issue("sub_zero",     1,   SUB,  32'h5,        32'h5,        4'b0001, 32'h0,        4'b0011);
      issue("add_cout",     1,   ADD,  32'hFFFFFFFF, 32'h1,        4'h0,    32'h0,        4'b0011);
      issue("sub_borrow",   1,   SUB,  32'h1,        32'h2,        4'b0001, 32'hFFFFFFFF, 4'b0100);
      issue("sub_cin0",     1,   SUB,  32'h5,        32'h3,        4'b0000, 32'h1,        4'b0001);
      issue("slt_neg",      1,   SLT,  32'hFFFFFFFF, 32'h1,        4'b1001, 32'h1,        4'b1001);
      issue("sltu_big",     1,   SLTU, 32'hFFFFFFFF, 32'h1,        4'h0,    32'h0,        4'b0010);
      issue("sltu_small",   1,   SLTU, 32'h1,        32'hFFFFFFFF, 4'h0,    32'h1,        4'b0000);
      issue("slt_eq_nocin", 1,   SLT,  32'h1,        32'h1,        4'h0,    32'h0,        4'b0010);
      issue("slt_ovf",      1,   SLT,  32'h80000000, 32'h1,        4'h0,    32'h1,        4'b0000);
      issue("unused_15",    1,   5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF,   32'h0,        4'b1011);
      issue("unused_31",    1,   5'd31, 32'h1234,    32'h5678,     4'h0,    32'h0,        4'b0010);
      // Back-to-back op changes, then a reset that discards a pending result.
      issue("b2b_and",      1,   AND,  32'hFF00FF00, 32'h0FF00FF0, 4'h0,    32'h0F000F00, 4'b0000);
      issue("b2b_add",      1,   ADD,  32'h10,       32'h20,       4'h0,    32'h30,       4'b0000);
      issue("b2b_sub",      1,   SUB,  32'h30,       32'h10,       4'b0001, 32'h20,       4'b0001);
      issue("pre_reset",    1,   ADD,  32'h1,        32'h2,        4'h0,    32'h3,        4'b0000);
      issue("mid_reset",    0,   OR,   32'hFFFFFFFF, 32'h0,        4'hF,    32'h0,        4'b0000);
      issue("post_reset",   1,   OR,   32'h00F0,     32'h0F00,     4'h0,    32'h0FF0,     4'b0000);
`ifdef ALU_SHIFT_EN
      issue("sra",          1,   SRA,  32'h80000000, 32'h4,        4'h0,    32'hF8000000, 4'b0100);
      issue("srl",          1,   SRL,  32'h80000000, 32'h4,        4'h0,    32'h08000000, 4'b0000);
      issue("sll_31",       1,   SLL,  32'h1,        32'd31,       4'h0,    32'h80000000, 4'b0100);
      issue("sll_mask",     1,   SLL,  32'h1,        32'h21,       4'b1001, 32'h2,        4'b1001);
`else
      issue("sll_unused",   1,   SLL,  32'h1,        32'h4,        4'b1001, 32'h0,        4'b1011);
      issue("sra_unused",   1,   SRA,  32'h80000000, 32'h4,        4'h0,    32'h0,        4'b0010);
`endif
      // Bounded drain: the monitor must consume the last entry within a few edges.
      repeat (3) @(posedge clk);
      #2;
      check("drain_queue_left", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

Parameterised integer ALU for the MIPS datapath, computing logic, add/subtract, compare and optional shift results from two operands and an incoming status word. It sits between the register-file/immediate operand muxes and the writeback/branch logic. Result and status outputs are registered, giving one cycle of latency.

## Interface
- `DATA_WIDTH`, default 32: operand/result width in bits; legal range 8–64.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `control`  in  5: operation select (codes below).
- `a`  in  DATA_WIDTH: operand A.
- `b`  in  DATA_WIDTH: operand B.
- `si`  in  4: status in; V=bit 3, N=bit 2, Z=bit 1, C=bit 0.
- `out`  out  DATA_WIDTH: registered result.
- `so`  out  4: registered status out, same bit layout as `si`.

## Operation
- Op codes:
  - AND=0: a & b.
  - OR=1: a | b.
  - NOR=2: ~(a | b).
  - ADD=3: a + b + si.C.
  - SUB=4: a + ~b + si.C. C=1 means no borrow, so si.C=1 gives a−b.
  - XOR=5: a ^ b.
  - SLT=6: signed a < b ? 1 : 0.
  - SLTU=7: unsigned a < b ? 1 : 0.
  - SLL=8, SRL=9, SRA=10: a shifted by b[log2(DATA_WIDTH)−1:0].
- ADD/SUB flags:
  - C = carry-out of the DATA_WIDTH-bit sum.
  - V = 1 when operand signs (after the B inversion for SUB) are equal and the result sign differs.
- SLT/SLTU compute a + ~b + 1 internally, independent of si.C.
- N = result MSB and Z = (result == 0) for every op, including SLT/SLTU.
- Logic, compare and shift ops pass si.C and si.V through to so unchanged.
- Unused codes 11–31: result 0, Z=1, N=0, C and V passed through from si.

## Timing
- Result and status are computed combinationally from the current inputs.
- `out` and `so` are registered on each rising `clk`: inputs present before edge k appear at the outputs after edge k (latency 1).
- No handshake. A new operation is accepted every cycle.
- `rst_n`=0 at a rising edge: `out`=0 and `so`=4'b0000 after that edge, regardless of the other inputs.
- Deasserting reset: the first edge with `rst_n`=1 captures the inputs present at that edge.
- Reset mid-stream discards the pending result. There is no other internal state.

## Configuration
- `ALU_SHIFT_EN` defined: SLL/SRL/SRA implemented as specified.
- Undefined: shifter logic omitted, and codes 8–10 behave as unused codes (result 0, Z=1).

## Structure
- Shared package `alu_pkg` holds:
  - op-code constants AND, OR, NOR, ADD, SUB, XOR, SLT, SLTU, SLL, SRL, SRA;
  - status bit indices STATUS_V_BIT=3, STATUS_N_BIT=2, STATUS_Z_BIT=1, STATUS_C_BIT=0.
- One sub-module `alu_adder` (DATA_WIDTH-bit adder with optional B inversion and carry-in, producing sum, carry-out and overflow) is shared by ADD, SUB, SLT and SLTU.
- The remaining datapath is a single result mux plus the output registers.

## Test plan
- Reset: hold `rst_n`=0 one edge with arbitrary inputs -> `out`=0, `so`=0.
- Logic, with a=F000000F, b=F00000F0, si=0:
  - AND -> F0000000, N=1, Z=0.
  - OR -> F00000FF, N=1.
  - NOR -> 0FFFFF00, N=0, V=0, C=0.
- Overflow: ADD with a=7FFFFFFF, b=1, si=0 -> 80000000, V=1, N=1, Z=0, C=0.
- Carry-in and subtract, with a=ABC, b=123, si.C=1:
  - ADD -> BE0, all flags 0.
  - SUB -> 999, C=1, V=0, N=0, Z=0.
- Compare/zero:
  - SUB with a=b=5, si.C=1 -> 0, Z=1, C=1.
  - SLT with a=FFFFFFFF, b=1 -> 1.
  - SLTU with the same operands -> 0, Z=1.
- Latency/back-to-back: change op every cycle (AND, ADD, SUB) -> each result appears exactly one edge later with no bubbles. With `ALU_SHIFT_EN`, SRA with a=80000000, b=4 -> F8000000.
